// File: rtl/softmax_sequencer.sv
// Sequencer between the dense layer and the fixed-latency softmax kernel.
// Holds one score vector on the kernel input, then serially scans the probabilities for the argmax.
module softmax_sequencer #(
  parameter int N_CLASS     = 10,
  parameter int BIT_DATA    = 8,
  parameter int BIT_SOFTMAX = 16,
  parameter int LATENCY     = 6,
  parameter int IDX_W       = $clog2(N_CLASS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIT_DATA*N_CLASS-1:0]   in_data,
  input  logic [BIT_SOFTMAX-1:0]        threshold,
  output logic [BIT_DATA*N_CLASS-1:0]   sm_x,
  input  logic [BIT_SOFTMAX*N_CLASS-1:0] sm_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_class,
  output logic [BIT_SOFTMAX-1:0]        out_prob,
  output logic                          early_term,
  output logic                          busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [BIT_DATA*N_CLASS-1:0] r_x;
  logic [BIT_SOFTMAX-1:0]  r_thr;
  logic [CNT_W-1:0]        r_cnt;
  logic [BIT_SOFTMAX-1:0]  r_y [N_CLASS];
  logic [IDX_W-1:0]        r_idx;
  logic [BIT_SOFTMAX-1:0]  r_max;
  logic [IDX_W-1:0]        r_max_class;
  logic [IDX_W-1:0]        r_out_class;
  logic [BIT_SOFTMAX-1:0]  r_out_prob;
  logic                    r_early;

  logic                    w_cnt_last;
  logic                    w_idx_last;
  logic [BIT_SOFTMAX-1:0]  w_cur;
  logic                    w_gt;
  logic [BIT_SOFTMAX-1:0]  w_new_max;
  logic [IDX_W-1:0]        w_new_class;

  assign w_cnt_last  = (r_cnt == CNT_W'(LATENCY - 1));
  assign w_idx_last  = (r_idx == IDX_W'(N_CLASS - 1));
  assign w_cur       = r_y[r_idx];
  // Strict compare keeps the earliest index on ties.
  assign w_gt        = (w_cur > r_max);
  assign w_new_max   = w_gt ? w_cur : r_max;
  assign w_new_class = w_gt ? r_idx : r_max_class;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid)   w_next = WAIT;
        WAIT:    if (w_cnt_last) w_next = SCAN;
        SCAN:    if (w_idx_last) w_next = DONE;
        DONE:    if (out_ready)  w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_thr       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_max_class <= '0;
      r_out_class <= '0;
      r_out_prob  <= '0;
      r_early     <= 1'b0;
      for (int unsigned i = 0; i < N_CLASS; i++) r_y[i] <= '0;
    end else if (abort) begin
      r_early <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= in_data;
            r_thr <= threshold;
            r_cnt <= '0;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_cnt_last) begin
            for (int unsigned i = 0; i < N_CLASS; i++)
              r_y[i] <= sm_y[BIT_SOFTMAX*i +: BIT_SOFTMAX];
            r_idx       <= '0;
            r_max       <= '0;
            r_max_class <= '0;
          end
        end
        SCAN: begin
          r_max       <= w_new_max;
          r_max_class <= w_new_class;
          r_idx       <= r_idx + IDX_W'(1);
          if (w_idx_last) begin
            r_out_class <= w_new_class;
            r_out_prob  <= w_new_max;
            r_early     <= (w_new_max >= r_thr);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign out_valid  = (r_state == DONE);
  assign sm_x       = r_x;
  assign out_class  = r_out_class;
  assign out_prob   = r_out_prob;
  assign early_term = r_early;

endmodule

// File: tb/tb_softmax_sequencer.sv
// Bench for softmax_sequencer: kernel stub maps score s to probability {s, 8'h00} through a delay line;
// results are checked against an argmax/threshold reference model.
module tb_softmax_sequencer;

  localparam int N   = 10;
  localparam int BD  = 8;
  localparam int BS  = 16;
  localparam int LAT = 6;
  localparam int IW  = $clog2(N);
  localparam int DW  = BD * N;
  localparam int YW  = BS * N;
  localparam int EXP_LAT = LAT + N;

  logic          clock = 1'b0;
  logic          reset, abort, in_valid, out_ready;
  logic          in_ready, out_valid, early_term, busy;
  logic [DW-1:0] in_data, sm_x;
  logic [BS-1:0] threshold, out_prob;
  logic [YW-1:0] sm_y;
  logic [IW-1:0] out_class;

  int n_cmp = 0;
  int n_bad = 0;

  softmax_sequencer #(.N_CLASS(N), .BIT_DATA(BD), .BIT_SOFTMAX(BS), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .threshold(threshold),
    .sm_x(sm_x), .sm_y(sm_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_prob(out_prob), .early_term(early_term), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [YW-1:0] stub(input logic [DW-1:0] x);
    logic [YW-1:0] y;
    for (int i = 0; i < N; i++) y[i*BS +: BS] = {x[i*BD +: BD], 8'h00};
    return y;
  endfunction

  // Kernel model: result settles before the LATENCY-th edge after sm_x changes.
  logic [YW-1:0] kpipe [LAT-1];
  always @(posedge clock) begin
    kpipe[0] <= stub(sm_x);
    for (int k = 1; k < LAT - 1; k++) kpipe[k] <= kpipe[k-1];
  end
  assign sm_y = kpipe[LAT-2];

  function automatic void ref_model(input logic [DW-1:0] d, input logic [BS-1:0] thr,
                                    output logic [IW-1:0] c, output logic [BS-1:0] p,
                                    output logic e);
    int unsigned pr [N];
    int unsigned best = 0;
    for (int i = 0; i < N; i++) begin
      pr[i] = {d[i*BD +: BD], 8'h00};
      if (pr[i] > best) best = pr[i];
    end
    c = '0;
    for (int i = N - 1; i >= 0; i--) if (pr[i] == best) c = IW'(i);
    p = BS'(best);
    e = (best >= int'(thr));
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*BD +: BD] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  function automatic logic [DW-1:0] fill_vec(input logic [7:0] base);
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*BD +: BD] = base;
    return d;
  endfunction

  task automatic accept_vector(input logic [DW-1:0] d, input logic [BS-1:0] thr);
    @(negedge clock);
    in_valid = 1'b1; in_data = d; threshold = thr;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; in_data = rand_vec(); threshold = BS'($urandom);
  endtask

  // Returns edges after accept at which out_valid was first seen (40 on timeout).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); lat++;
      @(negedge clock);
    end
  endtask

  task automatic consume();
    @(negedge clock); out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic ok = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || early_term !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got ov=%b busy=%b et=%b exp=0", out_valid, busy, early_term); end
    n_cmp++; if (sm_x !== '0 || out_class !== '0 || out_prob !== '0) begin
      n_bad++; $display("FAIL reset_data got sm_x=%h cls=%0d prob=%h exp=0", sm_x, out_class, out_prob); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); in_data = rand_vec();
      if (busy !== 1'b0 || in_ready !== 1'b1 || sm_x !== '0 || out_valid !== 1'b0) ok = 1'b0;
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL idle_hold got state change exp none"); end
  endtask

  task automatic test_directed();
    logic [DW-1:0] d;
    int lat;
    d = fill_vec(8'h01); d[7*BD +: BD] = 8'h90;
    accept_vector(d, 16'h8000);
    n_cmp++; if (sm_x !== d) begin n_bad++; $display("FAIL smx_latched got=%h exp=%h", sm_x, d); end
    wait_result(lat);
    n_cmp++; if (lat !== EXP_LAT) begin n_bad++; $display("FAIL latency_hi got=%0d exp=%0d", lat, EXP_LAT); end
    n_cmp++; if (out_class !== 4'd7 || out_prob !== 16'h9000 || early_term !== 1'b1) begin
      n_bad++; $display("FAIL result_hi got cls=%0d prob=%h et=%b exp 7 9000 1", out_class, out_prob, early_term); end
    consume();
    accept_vector(d, 16'hA000);
    wait_result(lat);
    n_cmp++; if (out_class !== 4'd7 || out_prob !== 16'h9000 || early_term !== 1'b0) begin
      n_bad++; $display("FAIL result_thr got cls=%0d prob=%h et=%b exp 7 9000 0", out_class, out_prob, early_term); end
    consume();
    d = fill_vec(8'h10); d[2*BD +: BD] = 8'h40; d[5*BD +: BD] = 8'h40;
    accept_vector(d, 16'h4000);
    wait_result(lat);
    n_cmp++; if (out_class !== 4'd2 || out_prob !== 16'h4000 || early_term !== 1'b1) begin
      n_bad++; $display("FAIL result_tie got cls=%0d prob=%h et=%b exp 2 4000 1", out_class, out_prob, early_term); end
    consume();
    accept_vector('0, 16'h0001);
    wait_result(lat);
    n_cmp++; if (out_class !== 4'd0 || out_prob !== 16'h0000 || early_term !== 1'b0) begin
      n_bad++; $display("FAIL result_zero got cls=%0d prob=%h et=%b exp 0 0000 0", out_class, out_prob, early_term); end
    consume();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic [IW-1:0] ec; logic [BS-1:0] ep; logic ee;
    int lat;
    logic ok = 1'b1;
    d = rand_vec();
    ref_model(d, 16'h7000, ec, ep, ee);
    accept_vector(d, 16'h7000);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== ec || out_prob !== ep ||
          early_term !== ee || sm_x !== d) ok = 1'b0;
      in_valid = 1'b1; in_data = rand_vec();
      @(negedge clock);
    end
    in_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL backpressure_hold got change exp cls=%0d prob=%h", ec, ep); end
    consume();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL release_ready got rdy=%b ov=%b exp 1 0", in_ready, out_valid); end
    d = rand_vec();
    ref_model(d, 16'h6000, ec, ep, ee);
    accept_vector(d, 16'h6000);
    wait_result(lat);
    n_cmp++; if (lat !== EXP_LAT || out_class !== ec || out_prob !== ep || early_term !== ee) begin
      n_bad++; $display("FAIL after_bp got lat=%0d cls=%0d prob=%h et=%b exp %0d %0d %h %b",
                        lat, out_class, out_prob, early_term, EXP_LAT, ec, ep, ee); end
    consume();
  endtask

  task automatic test_abort();
    logic [DW-1:0] d, dprev;
    logic [IW-1:0] pc; logic [BS-1:0] pp;
    logic [IW-1:0] ec; logic [BS-1:0] ep; logic ee;
    int lat;
    logic seen;
    for (int pass = 0; pass < 2; pass++) begin
      pc = out_class; pp = out_prob;
      accept_vector(rand_vec(), 16'h0000);
      repeat (pass == 0 ? 2 : LAT + 3) @(negedge clock);
      abort = 1'b1;
      @(negedge clock); abort = 1'b0;
      n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL abort_idle_%0d got busy=%b rdy=%b ov=%b exp 0 1 0", pass, busy, in_ready, out_valid); end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin @(negedge clock); if (out_valid !== 1'b0) seen = 1'b1; end
      n_cmp++; if (seen !== 1'b0 || out_class !== pc || out_prob !== pp) begin
        n_bad++; $display("FAIL abort_quiet_%0d got ov_seen=%b cls=%0d prob=%h exp 0 %0d %h",
                          pass, seen, out_class, out_prob, pc, pp); end
    end
    dprev = sm_x;
    @(negedge clock); in_valid = 1'b1; abort = 1'b1; in_data = ~dprev;
    @(negedge clock); in_valid = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || sm_x !== dprev) begin
      n_bad++; $display("FAIL abort_vs_accept got busy=%b sm_x=%h exp 0 %h", busy, sm_x, dprev); end
    d = rand_vec();
    ref_model(d, 16'h5000, ec, ep, ee);
    accept_vector(d, 16'h5000);
    wait_result(lat);
    n_cmp++; if (lat !== EXP_LAT || out_class !== ec || out_prob !== ep || early_term !== ee) begin
      n_bad++; $display("FAIL after_abort got lat=%0d cls=%0d prob=%h et=%b exp %0d %0d %h %b",
                        lat, out_class, out_prob, early_term, EXP_LAT, ec, ep, ee); end
    consume();
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] d;
    logic [IW-1:0] ec; logic [BS-1:0] ep; logic ee;
    int lat;
    d = fill_vec(8'h02); d[3*BD +: BD] = 8'hC0;
    accept_vector(d, 16'h0000);
    wait_result(lat);
    consume();
    accept_vector(rand_vec(), 16'h0000);
    repeat (LAT + 3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || early_term !== 1'b0 ||
                 sm_x !== '0 || out_class !== '0 || out_prob !== '0) begin
      n_bad++; $display("FAIL async_reset got busy=%b rdy=%b ov=%b et=%b smx=%h cls=%0d prob=%h exp reset values",
                        busy, in_ready, out_valid, early_term, sm_x, out_class, out_prob); end
    @(negedge clock); reset = 1'b0;
    d = rand_vec();
    ref_model(d, 16'h9000, ec, ep, ee);
    accept_vector(d, 16'h9000);
    wait_result(lat);
    n_cmp++; if (lat !== EXP_LAT || out_class !== ec || out_prob !== ep || early_term !== ee) begin
      n_bad++; $display("FAIL after_reset got lat=%0d cls=%0d prob=%h et=%b exp %0d %0d %h %b",
                        lat, out_class, out_prob, early_term, EXP_LAT, ec, ep, ee); end
    consume();
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [BS-1:0] thr;
    logic [IW-1:0] ec; logic [BS-1:0] ep; logic ee;
    int lat;
    for (int t = 0; t < 25; t++) begin
      d = rand_vec();
      if (t % 4 == 0) begin
        d = fill_vec(8'($urandom_range(0, 3)));
        d[$urandom_range(0, N-1)*BD +: BD] = 8'h80;
      end
      thr = BS'($urandom_range(0, 16'hFFFF));
      if (t % 3 == 0) begin
        ref_model(d, 16'h0000, ec, ep, ee);
        thr = ep;
      end
      ref_model(d, thr, ec, ep, ee);
      accept_vector(d, thr);
      wait_result(lat);
      n_cmp++; if (lat !== EXP_LAT || out_class !== ec || out_prob !== ep || early_term !== ee) begin
        n_bad++; $display("FAIL random_%0d got lat=%0d cls=%0d prob=%h et=%b exp %0d %0d %h %b",
                          t, lat, out_class, out_prob, early_term, EXP_LAT, ec, ep, ee); end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      consume();
    end
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; threshold = '0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
